// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider / tick generator.
// Divides clk by div_act (full output period in input cycles), producing a
// registered square wave (clk_out) and a one-cycle strobe (tick) per period.
// New divisors are staged and take effect only at cnt=0, so no period is ever
// cut short or stretched by a divisor change.
// Optional build macro: CLK_DIV_QUAD_OUT_EN adds clk_out_q, a quarter-period
// shifted copy of clk_out.
module clk_div_prog #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 1_000_000,
  parameter int MIN_DIV     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_err,
  output logic             div_pending,
  output logic [WIDTH-1:0] div_act,
  output logic             clk_out,
  output logic             tick
`ifdef CLK_DIV_QUAD_OUT_EN
  ,
  output logic             clk_out_q
`endif
);

  localparam logic [WIDTH-1:0] DEF_V  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam logic [WIDTH-1:0] FOUR_V = WIDTH'(4);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             load_ok;
  logic             wrap;
  logic [WIDTH-1:0] next_div;

`ifdef CLK_DIV_QUAD_OUT_EN
  logic             quad_q, quad_d;
  logic [WIDTH-1:0] quad_lo;
  logic [WIDTH-1:0] quad_hi;
`endif

  // Next-state logic: divisor staging, counter advance and output decode.
  always_comb begin
    load_ok  = div_load && (div_in >= MIN_V);
    wrap     = en && (cnt_q == (div_act_q - ONE_V));
    // A load arriving on the application edge wins over the staged value.
    next_div = load_ok ? div_in : (pend_vld_q ? pend_q : div_act_q);

    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = div_load && !load_ok;
    tick_d     = 1'b0;
    clk_d      = clk_q;

    if (load_ok) begin
      pend_d     = div_in;
      pend_vld_d = 1'b1;
    end

    if (sync_clr || wrap) begin
      // Period boundary: restart at 0 and apply any staged divisor. The
      // output is low at cnt=0 because every accepted divisor is >= 2.
      cnt_d      = '0;
      div_act_d  = next_div;
      pend_vld_d = 1'b0;
      tick_d     = !sync_clr;
      clk_d      = 1'b0;
    end else if (en) begin
      cnt_d = cnt_q + ONE_V;
      clk_d = (cnt_d >= (div_act_q >> 1));
    end

`ifdef CLK_DIV_QUAD_OUT_EN
    quad_lo = div_act_d >> 2;
    quad_hi = quad_lo + (div_act_d >> 1);
    quad_d  = quad_q;
    if (sync_clr) begin
      quad_d = 1'b0;
    end else if (en) begin
      // Below N=4 the quarter shift collapses to zero; mirror clk_out.
      if (div_act_d < FOUR_V) begin
        quad_d = (cnt_d >= (div_act_d >> 1));
      end else begin
        quad_d = (cnt_d >= quad_lo) && (cnt_d < quad_hi);
      end
    end
`endif
  end

  // State registers with synchronous reset dominating every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      div_act_q  <= DEF_V;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

`ifdef CLK_DIV_QUAD_OUT_EN
  // Quadrature output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      quad_q <= 1'b0;
    end else begin
      quad_q <= quad_d;
    end
  end

  assign clk_out_q = quad_q;
`endif

  assign div_err     = err_q;
  assign div_pending = pend_vld_q;
  assign div_act     = div_act_q;
  assign clk_out     = clk_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed bench for clk_div_prog with DEFAULT_DIV=10.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_clk_div_prog;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         en;
  logic         sync_clr;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_err;
  logic         div_pending;
  logic [W-1:0] div_act;
  logic         clk_out;
  logic         tick;
`ifdef CLK_DIV_QUAD_OUT_EN
  logic         clk_out_q;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int exp_n = 10;

  clk_div_prog #(
    .WIDTH(W),
    .DEFAULT_DIV(10),
    .MIN_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync_clr(sync_clr),
    .div_in(div_in),
    .div_load(div_load),
    .div_err(div_err),
    .div_pending(div_pending),
    .div_act(div_act),
    .clk_out(clk_out),
    .tick(tick)
`ifdef CLK_DIV_QUAD_OUT_EN
    ,
    .clk_out_q(clk_out_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("check %s: %0d ok", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n enabled edges, checking tick/clk_out against the expected phase.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      exp_cnt = (exp_cnt == exp_n - 1) ? 0 : exp_cnt + 1;
      chk("tick", {31'd0, tick}, {31'd0, exp_cnt == 0});
      chk("clk_out", {31'd0, clk_out}, {31'd0, exp_cnt >= exp_n / 2});
`ifdef CLK_DIV_QUAD_OUT_EN
      if (exp_n < 4)
        chk("clk_out_q", {31'd0, clk_out_q}, {31'd0, exp_cnt >= exp_n / 2});
      else
        chk("clk_out_q", {31'd0, clk_out_q},
            {31'd0, (exp_cnt >= exp_n / 4) && (exp_cnt < exp_n / 4 + exp_n / 2)});
`endif
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sync_clr = 1'b0; div_in = '0; div_load = 1'b0;

    // Reset values
    step();
    chk("rst_div_act", 32'(div_act), 32'd10);
    chk("rst_pending", {31'd0, div_pending}, 32'd0);
    chk("rst_err", {31'd0, div_err}, 32'd0);
    chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    reset = 1'b0; en = 1'b1;

    // Four default periods: ticks at 10,20,30,40, low 5 / high 5
    exp_cnt = 0; exp_n = 10;
    adv(40);
    chk("div_act_10", 32'(div_act), 32'd10);

    // Load 7 at cnt=3; applied at the next wrap without disturbing this period
    adv(3);
    div_in = 16'd7; div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    chk("pend_set", {31'd0, div_pending}, 32'd1);
    chk("act_still_10", 32'(div_act), 32'd10);
    adv(5);
    chk("pend_hold", {31'd0, div_pending}, 32'd1);
    adv(1);
    exp_n = 7;
    chk("act_7", 32'(div_act), 32'd7);
    chk("pend_clr", {31'd0, div_pending}, 32'd0);
    adv(14);

    // Rejected divisor 1
    div_in = 16'd1; div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    chk("err_pulse", {31'd0, div_err}, 32'd1);
    chk("err_act", 32'(div_act), 32'd7);
    chk("err_pend", {31'd0, div_pending}, 32'd0);
    adv(1);
    chk("err_gone", {31'd0, div_err}, 32'd0);

    // Minimum divisor 2
    div_in = 16'd2; div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    chk("pend_2", {31'd0, div_pending}, 32'd1);
    adv(3);
    adv(1);
    exp_n = 2;
    chk("act_2", 32'(div_act), 32'd2);
    adv(6);

    // Back to 10, then freeze at cnt=4 for 6 cycles with a load during freeze
    div_in = 16'd10; div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    adv(1);
    exp_n = 10;
    chk("act_10b", 32'(div_act), 32'd10);
    adv(4);
    en = 1'b0; div_in = 16'd7; div_load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      div_load = 1'b0;
      chk("frz_tick", {31'd0, tick}, 32'd0);
      chk("frz_clk", {31'd0, clk_out}, 32'd0);
      chk("frz_act", 32'(div_act), 32'd10);
`ifdef CLK_DIV_QUAD_OUT_EN
      chk("frz_quad", {31'd0, clk_out_q}, 32'd1);
`endif
    end
    chk("frz_pend", {31'd0, div_pending}, 32'd1);
    en = 1'b1;
    adv(1);
    adv(4);
    adv(1);
    exp_n = 7;
    chk("frz_act7", 32'(div_act), 32'd7);
    chk("frz_pend0", {31'd0, div_pending}, 32'd0);

    // Bypass load of 12 on the wrap edge
    adv(6);
    div_in = 16'd12; div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    exp_n = 12;
    chk("byp_act", 32'(div_act), 32'd12);
    chk("byp_pend", {31'd0, div_pending}, 32'd0);

    // sync_clr mid-period while clk_out is high
    adv(7);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    exp_cnt = 0;
    chk("clr_tick", {31'd0, tick}, 32'd0);
    chk("clr_clk", {31'd0, clk_out}, 32'd0);
`ifdef CLK_DIV_QUAD_OUT_EN
    chk("clr_quad", {31'd0, clk_out_q}, 32'd0);
`endif
    adv(12);

    // Reset together with load and sync_clr mid-period
    adv(3);
    reset = 1'b1; div_in = 16'd5; div_load = 1'b1; sync_clr = 1'b1;
    step();
    chk("rst2_act", 32'(div_act), 32'd10);
    chk("rst2_pend", {31'd0, div_pending}, 32'd0);
    chk("rst2_err", {31'd0, div_err}, 32'd0);
    chk("rst2_clk", {31'd0, clk_out}, 32'd0);
    chk("rst2_tick", {31'd0, tick}, 32'd0);
`ifdef CLK_DIV_QUAD_OUT_EN
    chk("rst2_quad", {31'd0, clk_out_q}, 32'd0);
`endif
    reset = 1'b0; div_load = 1'b0; sync_clr = 1'b0;
    exp_cnt = 0; exp_n = 10;
    adv(10);

    // Divisor 8: quadrature output high for cnt 2..5 when enabled
    div_in = 16'd8; div_load = 1'b1;
    adv(1);
    div_load = 1'b0;
    adv(9);
    exp_n = 8;
    chk("act_8", 32'(div_act), 32'd8);
    adv(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
